// File: rtl/alu_seq_if.sv
// Request/response bundle for the sequential ALU: operands and opcode in,
// handshake, result and FSM state out.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       select;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             illegal;
    logic [1:0]       fsm_state;

    // start is sampled only while busy=0; done is a one-cycle pulse marking
    // result/result_hi/zero/illegal valid, and a start during that cycle is accepted.
    modport master (
        output start, select, data1, data2,
        input  busy, done, result, result_hi, zero, illegal, fsm_state
    );

    modport slave (
        input  start, select, data1, data2,
        output busy, done, result, result_hi, zero, illegal, fsm_state
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU with iterative shifts and a shift-add multiplier.
// Define ALU_SEQ_MUL_EN to build the multiplier; otherwise opcode 100 reports illegal.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [CW-1:0]    count, count_d;
    logic [2:0]       op, op_d;
    logic [WIDTH-1:0] work, work_d;
    logic [WIDTH-1:0] result, result_d;
    logic [WIDTH-1:0] result_hi, result_hi_d;
    logic             zero, zero_d;
    logic             illegal, illegal_d;
    logic             done, done_d;

    logic             wr;
    logic [WIDTH-1:0] wr_val;
    logic [WIDTH-1:0] shifted;
    logic [SHW-1:0]   shamt;
`ifdef ALU_SEQ_MUL_EN
    // work doubles as the multiplier; acc holds the running upper half.
    logic [WIDTH-1:0] mcand, mcand_d;
    logic [WIDTH-1:0] acc, acc_d;
    logic [WIDTH:0]   sum;
`endif

    always_comb begin
        state_d     = state;
        count_d     = count;
        op_d        = op;
        work_d      = work;
        result_d    = result;
        result_hi_d = result_hi;
        zero_d      = zero;
        illegal_d   = 1'b0;
        done_d      = 1'b0;
        wr          = 1'b0;
        wr_val      = '0;
        shifted     = '0;
        shamt       = bus.data2[SHW-1:0];
`ifdef ALU_SEQ_MUL_EN
        mcand_d     = mcand;
        acc_d       = acc;
        sum         = '0;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
                    op_d = bus.select;
                    case (bus.select)
                        3'b000: begin wr = 1'b1; wr_val = bus.data2; end
                        3'b001: begin wr = 1'b1; wr_val = bus.data1 + bus.data2; end
                        3'b010: begin wr = 1'b1; wr_val = bus.data1 & bus.data2; end
                        3'b011: begin wr = 1'b1; wr_val = bus.data1 | bus.data2; end
                        3'b100: begin
`ifdef ALU_SEQ_MUL_EN
                            work_d  = bus.data2;
                            mcand_d = bus.data1;
                            acc_d   = '0;
                            count_d = CW'(WIDTH);
                            state_d = MUL;
`else
                            wr        = 1'b1;
                            wr_val    = '0;
                            illegal_d = 1'b1;
`endif
                        end
                        default: begin
                            if (shamt == '0) begin
                                wr     = 1'b1;
                                wr_val = bus.data1;
                            end else begin
                                work_d  = bus.data1;
                                count_d = CW'(shamt);
                                state_d = SHIFT;
                            end
                        end
                    endcase
                end
            end
            SHIFT: begin
                case (op)
                    3'b101:  shifted = work << 1;
                    3'b110:  shifted = work >> 1;
                    default: shifted = {work[WIDTH-1], work[WIDTH-1:1]};
                endcase
                work_d  = shifted;
                count_d = count - CW'(1);
                if (count == CW'(1)) begin
                    wr      = 1'b1;
                    wr_val  = shifted;
                    state_d = IDLE;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            MUL: begin
                sum     = {1'b0, acc} + (work[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
                acc_d   = sum[WIDTH:1];
                work_d  = {sum[0], work[WIDTH-1:1]};
                count_d = count - CW'(1);
                if (count == CW'(1)) begin
                    result_d    = work_d;
                    result_hi_d = acc_d;
                    zero_d      = ~|work_d;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        // Every non-MUL completion clears the high half; zero tracks the low half only.
        if (wr) begin
            result_d    = wr_val;
            result_hi_d = '0;
            zero_d      = ~|wr_val;
            done_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            op        <= '0;
            work      <= '0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b1;
            illegal   <= 1'b0;
            done      <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mcand     <= '0;
            acc       <= '0;
`endif
        end else begin
            state     <= state_d;
            count     <= count_d;
            op        <= op_d;
            work      <= work_d;
            result    <= result_d;
            result_hi <= result_hi_d;
            zero      <= zero_d;
            illegal   <= illegal_d;
            done      <= done_d;
`ifdef ALU_SEQ_MUL_EN
            mcand     <= mcand_d;
            acc       <= acc_d;
`endif
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = done;
    assign bus.result    = result;
    assign bus.result_hi = result_hi;
    assign bus.zero      = zero;
    assign bus.illegal   = illegal;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8); covers both settings of ALU_SEQ_MUL_EN.
module tb_alu_seq;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(WIDTH)) bus ();
    alu_seq #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Present a request (optionally waiting for a negedge first), hold it over one
    // rising edge, then scramble the operands so later changes are proven harmless.
    task automatic drive_start(input bit now, input logic [2:0] sel,
                               input logic [7:0] d1, input logic [7:0] d2);
        if (!now) @(negedge clk);
        bus.start  = 1'b1;
        bus.select = sel;
        bus.data1  = d1;
        bus.data2  = d2;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.select = 3'($urandom_range(0, 7));
        bus.data1  = 8'($urandom_range(0, 255));
        bus.data2  = 8'($urandom_range(0, 255));
    endtask

    // Step negedges until done, counting cycles with busy high beforehand.
    task automatic wait_done(input int limit, output int busy_cnt, output bit ok);
        busy_cnt = 0;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.select = 3'b000; bus.data1 = '0; bus.data2 = '0;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.result !== 8'h00) begin errors++; $display("FAIL reset_result: got %h want 00", bus.result); end
        checks++; if (bus.result_hi !== 8'h00) begin errors++; $display("FAIL reset_result_hi: got %h want 00", bus.result_hi); end
        checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", bus.zero); end
        checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", bus.illegal); end
        checks++; if (bus.fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.fsm_state); end
        rst = 1'b0;
    endtask

    task automatic test_logic_ops();
        int bc;
        bit ok;
        drive_start(1'b0, 3'b001, 8'h0C, 8'h02);
        wait_done(4, bc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL add_timeout: got no done want done"); end
        checks++; if (bc !== 0) begin errors++; $display("FAIL add_busy: got %0d want 0", bc); end
        checks++; if (bus.result !== 8'h0E) begin errors++; $display("FAIL add_result: got %h want 0e", bus.result); end
        checks++; if (bus.zero !== 1'b0) begin errors++; $display("FAIL add_zero: got %b want 0", bus.zero); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b want 0", bus.done); end

        drive_start(1'b0, 3'b001, 8'hFF, 8'h01);
        wait_done(4, bc, ok);
        checks++; if (bus.result !== 8'h00) begin errors++; $display("FAIL add_wrap_result: got %h want 00", bus.result); end
        checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL add_wrap_zero: got %b want 1", bus.zero); end

        drive_start(1'b0, 3'b000, 8'h5A, 8'hA5);
        wait_done(4, bc, ok);
        checks++; if (bus.result !== 8'hA5) begin errors++; $display("FAIL fwd_result: got %h want a5", bus.result); end

        drive_start(1'b0, 3'b010, 8'hF0, 8'h3C);
        wait_done(4, bc, ok);
        checks++; if (bus.result !== 8'h30) begin errors++; $display("FAIL and_result: got %h want 30", bus.result); end

        drive_start(1'b0, 3'b011, 8'h12, 8'h40);
        wait_done(4, bc, ok);
        checks++; if (bus.result !== 8'h52) begin errors++; $display("FAIL or_result: got %h want 52", bus.result); end
    endtask

    task automatic test_shifts();
        int bc;
        bit ok;
        drive_start(1'b0, 3'b111, 8'h80, 8'h03);
        wait_done(12, bc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sra_timeout: got no done want done"); end
        checks++; if (bc !== 3) begin errors++; $display("FAIL sra_busy: got %0d want 3", bc); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL sra_busy_at_done: got %b want 0", bus.busy); end
        checks++; if (bus.result !== 8'hF0) begin errors++; $display("FAIL sra_result: got %h want f0", bus.result); end

        drive_start(1'b0, 3'b101, 8'h81, 8'h00);
        wait_done(4, bc, ok);
        checks++; if (bc !== 0) begin errors++; $display("FAIL sll0_busy: got %0d want 0", bc); end
        checks++; if (bus.result !== 8'h81) begin errors++; $display("FAIL sll0_result: got %h want 81", bus.result); end

        drive_start(1'b0, 3'b101, 8'h03, 8'h02);
        wait_done(12, bc, ok);
        checks++; if (bus.result !== 8'h0C) begin errors++; $display("FAIL sll_result: got %h want 0c", bus.result); end

        // Only data2[2:0] counts as the shift amount: 0x0B shifts by 3.
        drive_start(1'b0, 3'b110, 8'hF0, 8'h0B);
        wait_done(12, bc, ok);
        checks++; if (bc !== 3) begin errors++; $display("FAIL srl_amt_busy: got %0d want 3", bc); end
        checks++; if (bus.result !== 8'h1E) begin errors++; $display("FAIL srl_amt_result: got %h want 1e", bus.result); end

        drive_start(1'b0, 3'b111, 8'h40, 8'h07);
        wait_done(12, bc, ok);
        checks++; if (bus.result !== 8'h00) begin errors++; $display("FAIL sra_pos_result: got %h want 00", bus.result); end
        checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL sra_pos_zero: got %b want 1", bus.zero); end
    endtask

    task automatic test_mul();
        int bc;
        bit ok;
        int extra;
`ifdef ALU_SEQ_MUL_EN
        drive_start(1'b0, 3'b100, 8'hFF, 8'hFF);
        @(negedge clk);
        // A request while busy must be dropped, not queued.
        bus.start = 1'b1; bus.select = 3'b001; bus.data1 = 8'h01; bus.data2 = 8'h01;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(20, bc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mul_timeout: got no done want done"); end
        checks++; if (bc !== 7) begin errors++; $display("FAIL mul_busy: got %0d want 7", bc); end
        checks++; if (bus.result !== 8'h01) begin errors++; $display("FAIL mul_lo: got %h want 01", bus.result); end
        checks++; if (bus.result_hi !== 8'hFE) begin errors++; $display("FAIL mul_hi: got %h want fe", bus.result_hi); end
        checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL mul_illegal: got %b want 0", bus.illegal); end
        extra = 0;
        repeat (4) begin @(negedge clk); if (bus.done === 1'b1) extra++; end
        checks++; if (extra !== 0) begin errors++; $display("FAIL mul_ignored_start: got %0d dones want 0", extra); end

        drive_start(1'b0, 3'b100, 8'h0C, 8'h0A);
        wait_done(20, bc, ok);
        checks++; if ({bus.result_hi, bus.result} !== 16'h0078) begin errors++; $display("FAIL mul_small: got %h want 0078", {bus.result_hi, bus.result}); end
        checks++; if (bus.zero !== 1'b0) begin errors++; $display("FAIL mul_small_zero: got %b want 0", bus.zero); end

        drive_start(1'b0, 3'b100, 8'h00, 8'h37);
        wait_done(20, bc, ok);
        checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL mul_zero_flag: got %b want 1", bus.zero); end
`else
        drive_start(1'b0, 3'b100, 8'hFF, 8'hFF);
        wait_done(4, bc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mul_off_timeout: got no done want done"); end
        checks++; if (bc !== 0) begin errors++; $display("FAIL mul_off_busy: got %0d want 0", bc); end
        checks++; if (bus.illegal !== 1'b1) begin errors++; $display("FAIL mul_off_illegal: got %b want 1", bus.illegal); end
        checks++; if (bus.result !== 8'h00) begin errors++; $display("FAIL mul_off_result: got %h want 00", bus.result); end
        checks++; if (bus.result_hi !== 8'h00) begin errors++; $display("FAIL mul_off_hi: got %h want 00", bus.result_hi); end
        checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL mul_off_zero: got %b want 1", bus.zero); end
        @(negedge clk);
        checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL mul_off_illegal_pulse: got %b want 0", bus.illegal); end
        extra = 0;
`endif
    endtask

    task automatic test_back_to_back();
        int bc;
        bit ok;
        drive_start(1'b0, 3'b110, 8'hF0, 8'h04);
        wait_done(12, bc, ok);
        checks++; if (bus.result !== 8'h0F) begin errors++; $display("FAIL b2b_srl: got %h want 0f", bus.result); end
        checks++; if (bus.result_hi !== 8'h00) begin errors++; $display("FAIL b2b_hi_clear: got %h want 00", bus.result_hi); end
        drive_start(1'b1, 3'b011, 8'h0F, 8'hF0);
        @(negedge clk);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", bus.done); end
        checks++; if (bus.result !== 8'hFF) begin errors++; $display("FAIL b2b_or: got %h want ff", bus.result); end
    endtask

    task automatic test_reset_abort();
        int dones;
`ifdef ALU_SEQ_MUL_EN
        drive_start(1'b0, 3'b100, 8'hFF, 8'hFF);
`else
        drive_start(1'b0, 3'b101, 8'h01, 8'h07);
`endif
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy: got %b want 1", bus.busy); end
        rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        checks++; if (bus.result !== 8'h00) begin errors++; $display("FAIL abort_result: got %h want 00", bus.result); end
        checks++; if (bus.result_hi !== 8'h00) begin errors++; $display("FAIL abort_hi: got %h want 00", bus.result_hi); end
        checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL abort_zero: got %b want 1", bus.zero); end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (12) begin @(negedge clk); if (bus.done === 1'b1) dones++; end
        checks++; if (dones !== 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", dones); end
    endtask

    initial begin
        test_reset();
        test_logic_ops();
        test_shifts();
        test_mul();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
